// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state type and op width for the ALU/mul-div block.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_OR    = 4'd2,
        OP_AND   = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiply and divide ops occupy the top of the op-code space.
    function automatic logic is_iterative(input logic [OP_W-1:0] op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / restoring-divide datapath: one step per cycle, XLEN steps.
// The final result is formed from the last step's next-state values so that
// done and result appear together in the cycle of the last iteration.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] hi_reg, lo_reg, opd_reg, src_a_reg;
    logic [SHW-1:0]  count_reg;
    logic            running_reg, mul_reg, high_reg, rem_reg;
    logic            neg_q_reg, neg_r_reg, div_zero_reg;

    logic            signed_div, a_neg, b_neg, is_mul;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] hi_next, lo_next, quo, rem;

    // Start decode: signed divides work on magnitudes, signs are restored at the end.
    always_comb begin
        is_mul     = (op == OP_MUL) || (op == OP_MULHU);
        signed_div = (op == OP_DIV) || (op == OP_REM);
        a_neg      = signed_div && src_a[XLEN-1];
        b_neg      = signed_div && src_b[XLEN-1];
        a_mag      = a_neg ? -src_a : src_a;
        b_mag      = b_neg ? -src_b : src_b;
    end

    // One shift-add (multiply) or shift-subtract (divide) step.
    always_comb begin
        sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
        shifted = {hi_reg, lo_reg[XLEN-1]};
        diff    = shifted - {1'b0, opd_reg};
        if (mul_reg) begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo_reg[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_next = diff[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], 1'b1};
        end else begin
            hi_next = shifted[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], 1'b0};
        end
    end

    // Result selection with sign fix-up and the divide-by-zero override.
    always_comb begin
        quo = neg_q_reg ? -lo_next : lo_next;
        rem = neg_r_reg ? -hi_next : hi_next;
        if (div_zero_reg) begin
            quo = '1;
            rem = src_a_reg;
        end
        if (mul_reg) begin
            result = high_reg ? hi_next : lo_next;
        end else begin
            result = rem_reg ? rem : quo;
        end
    end

    assign done = running_reg && (count_reg == '1);

    // Operand load on start, then one iteration per cycle until the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            opd_reg      <= '0;
            src_a_reg    <= '0;
            count_reg    <= '0;
            running_reg  <= 1'b0;
            mul_reg      <= 1'b0;
            high_reg     <= 1'b0;
            rem_reg      <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (start) begin
            hi_reg       <= '0;
            lo_reg       <= is_mul ? src_b : a_mag;
            opd_reg      <= is_mul ? src_a : b_mag;
            src_a_reg    <= src_a;
            count_reg    <= '0;
            running_reg  <= 1'b1;
            mul_reg      <= is_mul;
            high_reg     <= (op == OP_MULHU);
            rem_reg      <= (op == OP_REM) || (op == OP_REMU);
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= (src_b == '0);
        end else if (running_reg) begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if (done) begin
                running_reg <= 1'b0;
                count_reg   <= '0;
            end else begin
                count_reg <= count_reg + SHW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith/shift ops and iterative multiply/divide,
// behind a valid/ready request and a held result until consumed.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_e          state_reg, state_next;
    logic            accept, iterative, seq_done;
    logic [XLEN-1:0] alu_res, seq_result, result_reg;
    logic            zero_reg;
    logic [SHW-1:0]  shamt;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign iterative = is_iterative(op);
    assign shamt     = src_b[SHW-1:0];
    assign result    = result_reg;
    assign zero      = zero_reg;

    alu_muldiv_seq #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iterative),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .done   (seq_done),
        .result (seq_result)
    );

    // Single-cycle operations evaluated on the live request operands.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a + ~src_b + {{(XLEN-1){1'b0}}, 1'b1};
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = iterative ? BUSY : DONE;
            BUSY: if (seq_done) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result and zero flag capture; both stay frozen while DONE waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            zero_reg   <= 1'b1;
        end else if (accept && !iterative) begin
            result_reg <= alu_res;
            zero_reg   <= (alu_res == '0);
        end else if ((state_reg == BUSY) && seq_done) begin
            result_reg <= seq_result;
            zero_reg   <= (seq_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver queues expected results from a
// plain-arithmetic reference model; a negedge monitor checks every output.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero;
    logic [3:0]  op;
    logic [31:0] src_a, src_b, result;
    logic        bp_mode;
    int          cycle = 0;
    int          total = 0;
    int          passed = 0;
    logic        seen = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t scb[$];

    alu_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model straight from the op definitions.
    function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int              sa, sbv;
        int unsigned     sh;
        longint unsigned p;
        sa  = a;
        sbv = b;
        sh  = b % 32;
        p   = 64'(a) * 64'(b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sbv) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return sa >>> sh;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return sa / sbv;
            end
            4'd13: return (b == 0) ? 32'hFFFFFFFF : a / b;
            4'd14: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return sa % sbv;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present a request, wait for acceptance, queue the expectation, then scramble inputs.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        int   g;
        g        = 0;
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        while (!in_ready && g < 300) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 op=%0d", o);
            in_valid = 1'b0;
            return;
        end
        e.op  = o;
        e.a   = a;
        e.b   = b;
        e.res = ref_model(o, a, b);
        e.lat = (o >= 4'd10) ? 33 : 1;
        e.acc = cycle + 1;
        if (push) scb.push_back(e);
        tick();
        in_valid = 1'b0;
        op       = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((scb.size() != 0 || out_valid) && g < 500) begin
            tick();
            g++;
        end
        if (g >= 500) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending required 0", scb.size());
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first appearance, result/zero every valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (scb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got result %0h required no output", result);
            end else begin
                if (!seen) begin
                    check("latency", 64'(cycle - scb[0].acc + 1), 64'(scb[0].lat));
                    seen = 1'b1;
                end
                check("result", {32'h0, result}, {32'h0, scb[0].res});
                check("zero", {63'h0, zero}, {63'h0, (scb[0].res == 32'h0)});
                if (out_ready) begin
                    $display("txn op=%0d a=%08h b=%08h result=%08h zero=%0b",
                             scb[0].op, scb[0].a, scb[0].b, result, zero);
                    void'(scb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int g;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        src_a     = 32'h0;
        src_b     = 32'h0;
        bp_mode   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check("reset_result", {32'h0, result}, 64'h0);
        check("reset_zero", {63'h0, zero}, 64'h1);
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", {63'h0, in_ready}, 64'h1);

        // Directed corner cases.
        out_ready = 1'b1;
        issue(4'd0,  32'hFFFFFFFF, 32'h1, 1);
        wait_idle();
        bp_mode = 1'b1;
        issue(4'd9,  32'h80000000, 32'h24, 1);
        issue(4'd5,  32'hFFFFFFFF, 32'h1, 1);
        issue(4'd6,  32'hFFFFFFFF, 32'h1, 1);
        issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        issue(4'd12, 32'hFFFFFFF9, 32'h2, 1);
        issue(4'd14, 32'hFFFFFFF9, 32'h2, 1);
        issue(4'd13, 32'h5, 32'h0, 1);
        issue(4'd15, 32'h5, 32'h0, 1);
        issue(4'd12, 32'h80000000, 32'hFFFFFFFF, 1);
        issue(4'd14, 32'h80000000, 32'hFFFFFFFF, 1);
        issue(4'd12, 32'hFFFFFFF9, 32'h0, 1);
        wait_idle();

        // Consumer stall in DONE: result held, new requests refused.
        bp_mode   = 1'b0;
        out_ready = 1'b0;
        issue(4'd1, 32'h12345678, 32'h00000078, 1);
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        repeat (5) begin
            in_valid = 1'b1;
            op       = 4'd0;
            src_a    = $urandom;
            src_b    = $urandom;
            check("hold_in_ready", {63'h0, in_ready}, 64'h0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        wait_idle();

        // Reset in the middle of a divide: aborted, nothing produced afterwards.
        issue(4'd12, 32'hFFFFFFF9, 32'h2, 0);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'h0, out_valid}, 64'h0);
        check("abort_result", {32'h0, result}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (40) tick();
        issue(4'd12, 32'hFFFFFFF9, 32'h2, 1);
        wait_idle();

        // Random traffic with back-pressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 1);
        end
        wait_idle();
        repeat (5) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
